// File: rtl/csr_exec_unit_pkg.sv
// rtl/csr_exec_unit_pkg.sv - shared CSR op/state types and machine-mode CSR constants
package csr_exec_unit_pkg;

  // Operations the commit stage can hand to the unit; other encodings are dropped.
  typedef enum logic [2:0] {
    CSR_OP_RW    = 3'd1,
    CSR_OP_RS    = 3'd2,
    CSR_OP_RC    = 3'd3,
    CSR_OP_ECALL = 3'd4,
    CSR_OP_MRET  = 3'd5
  } csr_op_t;

  // Machine-mode CSR addresses touched by the trap sequences.
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MCYCLE  = 12'hB00;

  // mstatus field positions.
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Privilege encodings written into MPP.
  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [1:0] PRIV_U = 2'b00;

  // One state per register-file access; trap entry and return are fixed sequences.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_T_EPC,
    ST_T_CAUSE,
    ST_T_STATUS,
    ST_T_VEC,
    ST_R_STATUS,
    ST_R_EPC
  } csr_state_t;

  // Address bits [11:10] == 2'b11 mark a read-only CSR.
  function automatic logic csr_is_read_only(input logic [11:0] addr);
    return (addr[11:10] == 2'b11);
  endfunction

endpackage

// File: rtl/csr_exec_unit_if.sv
// rtl/csr_exec_unit_if.sv - request, response, redirect and register-file port bundle
interface csr_exec_unit_if #(
  parameter int XLEN = 64
);
  import csr_exec_unit_pkg::*;

  // commit-stage request
  logic            req_valid;
  logic            req_ready;
  csr_op_t         req_op;
  logic [11:0]     req_addr;
  logic [XLEN-1:0] req_src;
  logic [XLEN-1:0] req_pc;

  // pipeline response and fetch redirect
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  // CSR register-file port
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic            csr_we;
  logic [XLEN-1:0] csr_rdata;
  logic            mcycle_inc;

  // The execution unit.
  modport slave (
    input  req_valid, req_op, req_addr, req_src, req_pc, csr_rdata,
    output req_ready, resp_valid, resp_rdata, redirect_valid, redirect_pc,
           csr_addr, csr_wdata, csr_we, mcycle_inc
  );

  // The commit stage plus the register file around it.
  modport master (
    output req_valid, req_op, req_addr, req_src, req_pc, csr_rdata,
    input  req_ready, resp_valid, resp_rdata, redirect_valid, redirect_pc,
           csr_addr, csr_wdata, csr_we, mcycle_inc
  );

endinterface

// File: rtl/csr_exec_unit_alu.sv
// rtl/csr_exec_unit_alu.sv - read-modify-write result and write-enable for CSRRW/RS/RC
module csr_exec_unit_alu
  import csr_exec_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  csr_op_t         i_op,
  input  logic [11:0]     i_addr,
  input  logic [XLEN-1:0] i_old,
  input  logic [XLEN-1:0] i_src,
  output logic [XLEN-1:0] o_result,
  output logic            o_we
);

  logic w_src_zero;
  logic w_read_only;

  assign w_src_zero  = (i_src == '0);
  assign w_read_only = csr_is_read_only(i_addr);

  // New CSR value and whether the write actually happens; RS/RC with a zero mask are pure reads.
  always_comb begin
    o_result = i_src;
    o_we     = 1'b0;
    unique case (i_op)
      CSR_OP_RW: begin
        o_result = i_src;
        o_we     = !w_read_only;
      end
      CSR_OP_RS: begin
        o_result = i_old | i_src;
        o_we     = !w_read_only && !w_src_zero;
      end
      CSR_OP_RC: begin
        o_result = i_old & ~i_src;
        o_we     = !w_read_only && !w_src_zero;
      end
      default: begin
        o_result = i_src;
        o_we     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_exec_unit.sv
// rtl/csr_exec_unit.sv - CSR read/modify/write and ECALL/MRET sequencer over one register-file port
module csr_exec_unit
  import csr_exec_unit_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int ECALL_CAUSE = 11
) (
  input logic            clk,
  input logic            reset,
  csr_exec_unit_if.slave bus
);

  csr_state_t      r_state;
  csr_op_t         r_op;
  logic [11:0]     r_addr;
  logic [XLEN-1:0] r_src;
  logic [XLEN-1:0] r_pc;

  logic            w_accept;
  logic [XLEN-1:0] w_alu_result;
  logic            w_alu_we;
  logic [XLEN-1:0] w_status_trap;
  logic [XLEN-1:0] w_status_ret;

  assign w_accept = bus.req_valid && bus.req_ready;

  csr_exec_unit_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .i_op     (r_op),
    .i_addr   (r_addr),
    .i_old    (bus.csr_rdata),
    .i_src    (r_src),
    .o_result (w_alu_result),
    .o_we     (w_alu_we)
  );

  // mstatus images for trap entry and trap return, built from the value currently on csr_rdata.
  always_comb begin
    w_status_trap                                = bus.csr_rdata;
    w_status_trap[MSTATUS_MPIE]                  = bus.csr_rdata[MSTATUS_MIE];
    w_status_trap[MSTATUS_MIE]                   = 1'b0;
    w_status_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;

    w_status_ret                                 = bus.csr_rdata;
    w_status_ret[MSTATUS_MIE]                    = bus.csr_rdata[MSTATUS_MPIE];
    w_status_ret[MSTATUS_MPIE]                   = 1'b1;
    w_status_ret[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = PRIV_U;
  end

  // Sequencer state and the request fields latched on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= CSR_OP_RW;
      r_addr  <= '0;
      r_src   <= '0;
      r_pc    <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op   <= bus.req_op;
            r_addr <= bus.req_addr;
            r_src  <= bus.req_src;
            r_pc   <= bus.req_pc;
            unique case (bus.req_op)
              CSR_OP_RW, CSR_OP_RS, CSR_OP_RC: r_state <= ST_EXEC;
              CSR_OP_ECALL:                    r_state <= ST_T_EPC;
              CSR_OP_MRET:                     r_state <= ST_R_STATUS;
              default:                         r_state <= ST_IDLE;
            endcase
          end
        end
        ST_EXEC:     r_state <= ST_IDLE;
        ST_T_EPC:    r_state <= ST_T_CAUSE;
        ST_T_CAUSE:  r_state <= ST_T_STATUS;
        ST_T_STATUS: r_state <= ST_T_VEC;
        ST_T_VEC:    r_state <= ST_IDLE;
        ST_R_STATUS: r_state <= ST_R_EPC;
        ST_R_EPC:    r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  // All outputs decode from state and latched fields; reset forces every output to its idle value.
  always_comb begin
    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.resp_rdata     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.csr_addr       = '0;
    bus.csr_wdata      = '0;
    bus.csr_we         = 1'b0;
    bus.mcycle_inc     = 1'b0;
    if (!reset) begin
      bus.mcycle_inc = 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          bus.req_ready = 1'b1;
        end
        ST_EXEC: begin
          bus.csr_addr   = r_addr;
          bus.csr_wdata  = w_alu_result;
          bus.csr_we     = w_alu_we;
          bus.resp_valid = 1'b1;
          bus.resp_rdata = bus.csr_rdata;
        end
        ST_T_EPC: begin
          bus.csr_addr  = CSR_MEPC;
          bus.csr_wdata = r_pc & ~XLEN'(1);
          bus.csr_we    = 1'b1;
        end
        ST_T_CAUSE: begin
          bus.csr_addr  = CSR_MCAUSE;
          bus.csr_wdata = XLEN'(unsigned'(ECALL_CAUSE));
          bus.csr_we    = 1'b1;
        end
        ST_T_STATUS: begin
          bus.csr_addr  = CSR_MSTATUS;
          bus.csr_wdata = w_status_trap;
          bus.csr_we    = 1'b1;
        end
        ST_T_VEC: begin
          // Only direct-mode vectoring: the mode bits are simply masked off.
          bus.csr_addr       = CSR_MTVEC;
          bus.redirect_valid = 1'b1;
          bus.redirect_pc    = bus.csr_rdata & ~XLEN'(3);
        end
        ST_R_STATUS: begin
          bus.csr_addr  = CSR_MSTATUS;
          bus.csr_wdata = w_status_ret;
          bus.csr_we    = 1'b1;
        end
        ST_R_EPC: begin
          bus.csr_addr       = CSR_MEPC;
          bus.redirect_valid = 1'b1;
          bus.redirect_pc    = bus.csr_rdata;
        end
        default: begin
          bus.req_ready = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/csr_exec_unit.md
Name: csr_exec_unit

Overview:
- Sits between the commit stage and the CSR register file. Upstream: a valid/ready request. Downstream: the register file's single read/write port (addr, wdata, we, combinational rdata) and its mcycle_inc input.
- Executes CSRRW/CSRRS/CSRRC and sequences the multi-write ECALL trap entry and MRET return over that one port.
- Returns the old CSR value and a PC redirect to the pipeline.

Parameters:
- XLEN, 64, data width
- ECALL_CAUSE, 11, mcause value written on ECALL from M-mode

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request offered by commit stage
- req_ready  out  1  unit can accept a request
- req_op  in  3  csr_op_t: CSRRW, CSRRS, CSRRC, ECALL, MRET
- req_addr  in  12  CSR address (ignored for ECALL/MRET)
- req_src  in  XLEN  rs1 value or zero-extended zimm
- req_pc  in  XLEN  PC of the requesting instruction
- resp_valid  out  1  one-cycle pulse: CSR op done, resp_rdata valid
- resp_rdata  out  XLEN  old CSR value, for writeback to rd
- redirect_valid  out  1  one-cycle pulse: fetch must jump to redirect_pc
- redirect_pc  out  XLEN  trap vector or return PC
- csr_addr  out  12  register-file address
- csr_wdata  out  XLEN  register-file write data
- csr_we  out  1  register-file write enable
- csr_rdata  in  XLEN  register-file combinational read data
- mcycle_inc  out  1  cycle-counter increment

Behaviour:
- Reset values: state IDLE. req_ready=0 while reset is high, 1 in the first IDLE cycle after reset. resp_valid, redirect_valid, csr_we, mcycle_inc = 0. csr_addr, csr_wdata, resp_rdata, redirect_pc = 0.
- mcycle_inc = 1 in every non-reset cycle. The register file gives a same-cycle mcycle write priority over the increment.
- req_ready = (state==IDLE). On req_valid && req_ready, latch op, addr, src and pc, then go to the state for that op.
- Only the states below drive csr_we high. csr_addr = 0 in IDLE.
- EXEC, entered for CSRRW/RS/RC (1 cycle):
  - csr_addr = latched addr; old = csr_rdata.
  - new value: RW = src; RS = old | src; RC = old & ~src.
  - csr_we = 1, except: addr[11:10]==2'b11 (read-only); or op is RS/RC with src==0. No write means no write to mcycle either.
  - resp_valid = 1, resp_rdata = old. Next state IDLE.
  - Latency: accept at cycle N, response at N+1, next accept possible at N+2.
- ECALL sequence, 4 cycles, no resp_valid:
  - T_EPC: write mepc (0x341) = pc & ~1.
  - T_CAUSE: write mcause (0x342) = ECALL_CAUSE.
  - T_STATUS: read mstatus (0x300) and write it back modified: MPIE[7] = old MIE[3]; MIE = 0; MPP[12:11] = 2'b11; other bits unchanged.
  - T_VEC: read mtvec (0x305), no write. redirect_valid = 1, redirect_pc = mtvec & ~3 (direct mode only). Next state IDLE.
- MRET sequence, 2 cycles:
  - R_STATUS: write mstatus with MIE = old MPIE; MPIE = 1; MPP = 2'b00.
  - R_EPC: read mepc, no write. redirect_valid = 1, redirect_pc = mepc. Next state IDLE.
- Sequences cannot be aborted. A flush arriving mid-sequence is the upstream's problem.
- Reset mid-sequence: return to IDLE next edge. Partial CSR writes already done are not undone; the register file resets them anyway.
- Unknown req_op value: accepted and dropped, no outputs, stays IDLE.
- Outputs are combinational from state and latched fields. Only the state and latch registers are flopped.

Decomposition:
- Shared CSR package:
  - csr_op_t enum
  - CSR address constants for mstatus, mtvec, mepc, mcause, mcycle
  - mstatus bit-position constants MIE=3, MPIE=7, MPP=12:11
  - csr_state_t enum for IDLE/EXEC/T_EPC/T_CAUSE/T_STATUS/T_VEC/R_STATUS/R_EPC
- Optional sub-module csr_alu: pure combinational RW/RS/RC result plus write-suppress flag. Everything else lives in one module.

Test Plan:
- CSRRW mscratch (0x340) with src=0xDEAD, register holds 0x5 -> one cycle later: resp_rdata=0x5, csr_we=1, csr_wdata=0xDEAD.
- CSRRS mcycle with src=0, mcycle=100 -> resp_rdata=100, csr_we=0, mcycle keeps incrementing.
- CSRRC mstatus with src=0x8, mstatus=0x88 -> csr_wdata=0x80.
- CSRRW mhartid (0xF14) -> csr_we stays 0, resp_rdata=0.
- ECALL at pc=0x8000_0010, mstatus=0x8, mtvec=0x8000_0101:
  - cycles 1..4 write mepc=0x8000_0010, then mcause=11, then mstatus=0x1880.
  - redirect_pc=0x8000_0100 in cycle 4.
  - req_ready low for 4 cycles.
- MRET with mstatus=0x1880, mepc=0x8000_0014 -> mstatus written 0x88, then redirect_pc=0x8000_0014.
- Reset asserted during T_CAUSE -> IDLE next cycle, redirect_valid never pulses, req_ready=1 after reset drops.
